// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage and data memory.
// One access is outstanding at a time. req is held until ack.
// rdata is valid in the same cycle as ack.
//   master (mem_stage): drives req, we, addr, wdata, wstrb; receives ack, rdata
//   slave  (memory)   : the reverse
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
    modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: sits between EX/MEM and mem_wb_reg.
// Issues loads and stores over the dmem req/ack bus, and stalls upstream while an
// access is outstanding. It aligns store lanes and extends load data. It registers
// the write-back payload.
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   ex_mem_*                  instruction from the EX/MEM register
//   dmem                      data-memory bus (master side)
//   mem_stall                 combinational; upstream holds EX/MEM while high
//   misalign_exc              one-cycle pulse after a misaligned access is dropped
//   mem_wb_*                  registered write-back payload
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_mem_valid,
    input  logic [4:0]      ex_mem_rdaddr,
    input  logic [XLEN-1:0] ex_mem_alu_result,
    input  logic [XLEN-1:0] ex_mem_rs2data,
    input  logic            ex_mem_memread,
    input  logic            ex_mem_memwrite,
    input  logic [2:0]      ex_mem_funct3,
    input  logic            ex_mem_regwrite,
    mem_stage_if.master     dmem,
    output logic            mem_stall,
    output logic            misalign_exc,
    output logic            mem_wb_valid,
    output logic [4:0]      mem_wb_rdaddr,
    output logic [XLEN-1:0] mem_wb_wbdata,
    output logic            mem_wb_regwrite
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state;

    // Fields of the accepted memory op. They are captured at issue so that write-back
    // does not depend on upstream still holding EX/MEM.
    logic [4:0]  pend_rd;
    logic        pend_rw;
    logic        pend_load;
    logic [2:0]  pend_f3;
    logic [1:0]  pend_off;
    logic [31:0] pend_alu;

    logic        is_mem, acc_byte, acc_half, acc_word, misalign, accept;
    logic [1:0]  off;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign is_mem = ex_mem_memread | ex_mem_memwrite;
    assign off    = ex_mem_alu_result[1:0];

    // funct3[2] selects zero-extension only for loads. A store with funct3 1xx is a
    // full-word store.
    assign acc_byte = (ex_mem_funct3[1:0] == 2'b00) & (~ex_mem_funct3[2] | ex_mem_memread);
    assign acc_half = (ex_mem_funct3[1:0] == 2'b01) & (~ex_mem_funct3[2] | ex_mem_memread);
    assign acc_word = ~acc_byte & ~acc_half;

    assign misalign = is_mem & ((acc_half & off[0]) | (acc_word & (off != 2'b00)));
    assign accept   = (state == S_IDLE) & ex_mem_valid & is_mem & ~misalign;

    assign mem_stall = accept | ((state == S_WAIT) & ~dmem.ack);

    always_comb begin
        st_strb = 4'b1111;
        st_data = ex_mem_rs2data;
        if (acc_byte) begin
            st_strb = 4'b0001 << off;
            st_data = {4{ex_mem_rs2data[7:0]}};
        end else if (acc_half) begin
            st_strb = 4'b0011 << off;
            st_data = {2{ex_mem_rs2data[15:0]}};
        end
    end

    always_comb begin
        ld_byte = dmem.rdata[{pend_off, 3'b000} +: 8];
        ld_half = pend_off[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        case (pend_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem.rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            dmem.req        <= 1'b0;
            dmem.we         <= 1'b0;
            dmem.addr       <= '0;
            dmem.wdata      <= '0;
            dmem.wstrb      <= '0;
            misalign_exc    <= 1'b0;
            mem_wb_valid    <= 1'b0;
            mem_wb_rdaddr   <= '0;
            mem_wb_wbdata   <= '0;
            mem_wb_regwrite <= 1'b0;
            pend_rd         <= '0;
            pend_rw         <= 1'b0;
            pend_load       <= 1'b0;
            pend_f3         <= '0;
            pend_off        <= '0;
            pend_alu        <= '0;
        end else begin
            misalign_exc <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!ex_mem_valid) begin
                        mem_wb_valid    <= 1'b0;
                        mem_wb_regwrite <= 1'b0;
                    end else if (!is_mem) begin
                        mem_wb_valid    <= 1'b1;
                        mem_wb_rdaddr   <= ex_mem_rdaddr;
                        mem_wb_wbdata   <= ex_mem_alu_result;
                        mem_wb_regwrite <= ex_mem_regwrite;
                    end else if (misalign) begin
                        misalign_exc    <= 1'b1;
                        mem_wb_valid    <= 1'b0;
                        mem_wb_regwrite <= 1'b0;
                    end else begin
                        state           <= S_WAIT;
                        dmem.req        <= 1'b1;
                        dmem.we         <= ex_mem_memwrite;
                        dmem.addr       <= {ex_mem_alu_result[31:2], 2'b00};
                        dmem.wdata      <= st_data;
                        dmem.wstrb      <= ex_mem_memwrite ? st_strb : 4'b0000;
                        mem_wb_valid    <= 1'b0;
                        mem_wb_regwrite <= 1'b0;
                        pend_rd         <= ex_mem_rdaddr;
                        pend_rw         <= ex_mem_regwrite;
                        pend_load       <= ex_mem_memread;
                        pend_f3         <= ex_mem_funct3;
                        pend_off        <= off;
                        pend_alu        <= ex_mem_alu_result;
                    end
                end
                S_WAIT: begin
                    if (dmem.ack) begin
                        state           <= S_IDLE;
                        dmem.req        <= 1'b0;
                        mem_wb_valid    <= 1'b1;
                        mem_wb_rdaddr   <= pend_rd;
                        mem_wb_regwrite <= pend_rw;
                        mem_wb_wbdata   <= pend_load ? ld_data : pend_alu;
                    end else begin
                        mem_wb_valid    <= 1'b0;
                        mem_wb_regwrite <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage. Directed cases come first, then randomized ops, all checked
// against a transaction-level reference model. Inputs change 1 time unit after the
// rising edge. Registered outputs are checked at that point. The combinational
// mem_stall is checked 1 time unit later.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_mem_valid = 1'b0;
    logic [4:0]  ex_mem_rdaddr = '0;
    logic [31:0] ex_mem_alu_result = '0;
    logic [31:0] ex_mem_rs2data = '0;
    logic        ex_mem_memread = 1'b0;
    logic        ex_mem_memwrite = 1'b0;
    logic [2:0]  ex_mem_funct3 = '0;
    logic        ex_mem_regwrite = 1'b0;
    logic        mem_stall, misalign_exc, mem_wb_valid, mem_wb_regwrite;
    logic [4:0]  mem_wb_rdaddr;
    logic [31:0] mem_wb_wbdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_stage_if dmem();

    mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .ex_mem_valid      (ex_mem_valid),
        .ex_mem_rdaddr     (ex_mem_rdaddr),
        .ex_mem_alu_result (ex_mem_alu_result),
        .ex_mem_rs2data    (ex_mem_rs2data),
        .ex_mem_memread    (ex_mem_memread),
        .ex_mem_memwrite   (ex_mem_memwrite),
        .ex_mem_funct3     (ex_mem_funct3),
        .ex_mem_regwrite   (ex_mem_regwrite),
        .dmem              (dmem),
        .mem_stall         (mem_stall),
        .misalign_exc      (misalign_exc),
        .mem_wb_valid      (mem_wb_valid),
        .mem_wb_rdaddr     (mem_wb_rdaddr),
        .mem_wb_wbdata     (mem_wb_wbdata),
        .mem_wb_regwrite   (mem_wb_regwrite)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- reference model: access rules expressed arithmetically ----
    function automatic int acc_size(input logic ld, input logic [2:0] f3);
        if (f3 == 3'd0 || (ld && f3 == 3'd4)) return 1;
        if (f3 == 3'd1 || (ld && f3 == 3'd5)) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] sh, v;
        sh = rdata >> (8 * (addr % 4));
        case (f3)
            3'd0: begin v = sh % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
            3'd1: begin v = sh % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
            3'd4: v = sh % 256;
            3'd5: v = sh % 65536;
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_strb(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = acc_size(1'b0, f3);
        if (sz == 4) return 32'hF;
        return ((1 << sz) - 1) << (addr % 4);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (acc_size(1'b0, f3))
            1:       return (rs2 % 256) * 32'h0101_0101;
            2:       return (rs2 % 65536) * 32'h0001_0001;
            default: return rs2;
        endcase
    endfunction

    // Present one instruction, run it to completion, and check every cycle. It returns
    // 1 time unit after the edge that retires the instruction, so the next op can go
    // back-to-back.
    task automatic run_op(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                          input logic rw, input int dly, input logic [31:0] rdata,
                          input logic spur);
        int lat;
        logic misal;
        ex_mem_valid      = v;
        ex_mem_memread    = ld;
        ex_mem_memwrite   = st;
        ex_mem_funct3     = f3;
        ex_mem_alu_result = addr;
        ex_mem_rs2data    = rs2;
        ex_mem_rdaddr     = rd;
        ex_mem_regwrite   = rw;
        misal = (addr % acc_size(ld, f3)) != 0;
        dmem.ack = spur;
        #1;
        if (!v) begin
            chk("idle_stall", mem_stall, 0);
            tick();
            dmem.ack = 1'b0;
            chk("idle_valid", mem_wb_valid, 0);
            chk("idle_rw", mem_wb_regwrite, 0);
            chk("idle_req", dmem.req, 0);
        end else if (!(ld || st)) begin
            chk("alu_stall", mem_stall, 0);
            tick();
            dmem.ack = 1'b0;
            chk("alu_valid", mem_wb_valid, 1);
            chk("alu_rd", mem_wb_rdaddr, rd);
            chk("alu_data", mem_wb_wbdata, addr);
            chk("alu_rw", mem_wb_regwrite, rw);
            chk("alu_req", dmem.req, 0);
            chk("alu_exc", misalign_exc, 0);
        end else if (misal) begin
            chk("mis_stall", mem_stall, 0);
            tick();
            chk("mis_exc", misalign_exc, 1);
            chk("mis_valid", mem_wb_valid, 0);
            chk("mis_rw", mem_wb_regwrite, 0);
            chk("mis_req", dmem.req, 0);
        end else begin
            chk("acc_stall", mem_stall, 1);
            tick();
            lat = 1;
            chk("iss_req", dmem.req, 1);
            chk("iss_we", dmem.we, st);
            chk("iss_addr", dmem.addr, addr & 32'hFFFF_FFFC);
            chk("iss_strb", dmem.wstrb, st ? exp_strb(f3, addr) : 32'h0);
            if (st) chk("iss_wdata", dmem.wdata, exp_wdata(f3, rs2));
            chk("iss_valid", mem_wb_valid, 0);
            chk("iss_exc", misalign_exc, 0);
            for (int i = 0; i < dly; i++) begin
                #1;
                chk("wait_stall", mem_stall, 1);
                tick();
                lat++;
                chk("wait_req", dmem.req, 1);
                chk("wait_addr", dmem.addr, addr & 32'hFFFF_FFFC);
                chk("wait_valid", mem_wb_valid, 0);
            end
            dmem.ack   = 1'b1;
            dmem.rdata = rdata;
            #1;
            chk("ack_stall", mem_stall, 0);
            tick();
            lat++;
            dmem.ack   = 1'b0;
            dmem.rdata = $urandom;
            chk("wb_valid", mem_wb_valid, 1);
            chk("wb_rd", mem_wb_rdaddr, rd);
            chk("wb_rw", mem_wb_regwrite, rw);
            chk("wb_data", mem_wb_wbdata, ld ? exp_load(f3, addr, rdata) : addr);
            chk("wb_req", dmem.req, 0);
            chk("wb_lat", lat, 2 + dly);
        end
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        dmem.ack   = 1'b0;
        dmem.rdata = '0;

        tick();
        tick();
        chk("rst_req", dmem.req, 0);
        chk("rst_we", dmem.we, 0);
        chk("rst_addr", dmem.addr, 0);
        chk("rst_wdata", dmem.wdata, 0);
        chk("rst_strb", dmem.wstrb, 0);
        chk("rst_valid", mem_wb_valid, 0);
        chk("rst_rd", mem_wb_rdaddr, 0);
        chk("rst_data", mem_wb_wbdata, 0);
        chk("rst_rw", mem_wb_regwrite, 0);
        chk("rst_exc", misalign_exc, 0);
        rst = 1'b1;

        // directed cases
        run_op(1, 0, 0, 3'd0, 32'h0000_1234, 0, 5'd5, 1, 0, 0, 0);
        run_op(1, 1, 0, 3'd0, 32'h0000_0103, 0, 5'd7, 1, 3, 32'h80FF_FF7F, 0);
        run_op(1, 0, 1, 3'd1, 32'h0000_0202, 32'hDEAD_BEEF, 5'd0, 0, 1, 0, 0);
        run_op(1, 1, 0, 3'd2, 32'h0000_0006, 0, 5'd9, 1, 0, 0, 0);
        run_op(1, 0, 0, 3'd0, 32'hCAFE_0001, 0, 5'd3, 1, 0, 0, 1);
        run_op(1, 1, 0, 3'd0, 32'h0000_0010, 0, 5'd4, 1, 0, 32'h1234_5678, 0);

        // reset in the middle of WAIT; an ack that arrives later must be ignored
        ex_mem_valid = 1; ex_mem_memread = 1; ex_mem_memwrite = 0;
        ex_mem_funct3 = 3'd2; ex_mem_alu_result = 32'h40; ex_mem_rdaddr = 5'd8;
        ex_mem_regwrite = 1;
        tick();
        chk("rw_req", dmem.req, 1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        ex_mem_valid = 0; ex_mem_memread = 0;
        chk("rw_req0", dmem.req, 0);
        chk("rw_addr0", dmem.addr, 0);
        chk("rw_valid0", mem_wb_valid, 0);
        chk("rw_data0", mem_wb_wbdata, 0);
        dmem.ack = 1'b1;
        dmem.rdata = 32'hFFFF_FFFF;
        #1;
        chk("rw_stall", mem_stall, 0);
        tick();
        dmem.ack = 1'b0;
        chk("rw_late_valid", mem_wb_valid, 0);
        chk("rw_late_req", dmem.req, 0);

        // randomized ops
        for (int n = 0; n < 250; n++) begin
            int kind;
            logic [2:0] f3;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            case (kind)
                0: run_op(1, 0, 0, 3'($urandom), a, $urandom, 5'($urandom), 1'($urandom),
                          0, 0, 1'($urandom));
                1: begin
                    f3 = ld_f3[$urandom_range(0, 4)];
                    run_op(1, 1, 0, f3, a, $urandom, 5'($urandom), 1'($urandom),
                           $urandom_range(0, 4), $urandom, 0);
                end
                2: begin
                    f3 = 3'($urandom_range(0, 2));
                    run_op(1, 0, 1, f3, a, $urandom, 5'($urandom), 1'($urandom),
                           $urandom_range(0, 4), $urandom, 0);
                end
                default: run_op(0, 1'($urandom), 0, 3'($urandom), a, $urandom, 5'($urandom),
                                1'($urandom), 0, 0, 1'($urandom));
            endcase
        end
        ex_mem_valid = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
